// File: rtl/auto_contrast_stat_pkg.sv
// Shared constants and FSM encoding for the auto-contrast statistics block.
package auto_contrast_stat_pkg;

    // Contrast coefficient format: unsigned Q3.6, 0x40 = 1.0
    localparam int unsigned COE_WIDTH          = 9;
    localparam int unsigned COE_FRACTION_WIDTH = 6;
    localparam int unsigned COE_ONE            = 64;
    localparam int unsigned COE_MAX            = 511;

    // 255 * 64: full output range expressed in coefficient units
    localparam int unsigned FULL_SCALE_X64     = 16320;

    // Cycles from the first vs_i-high sample to the upd_o pulse
    localparam int unsigned ACS_LATENCY        = 20;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSnap = 3'd1,
        StDiv  = 3'd2,
        StMul  = 3'd3,
        StOut  = 3'd4
    } acs_state_e;

endpackage

// File: rtl/auto_contrast_stat_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// A start pulse (also while busy) loads the operands and restarts the division.
module auto_contrast_stat_seq_div #(
    parameter int unsigned DIVIDEND_WIDTH = 15,
    parameter int unsigned DIVISOR_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o
);
    localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);

    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  divisor_q;
    logic [CntW-1:0]           cnt_q;
    logic                      busy_q, done_q;
    logic [DIVISOR_WIDTH:0]    trial, diff;
    logic                      fits;
    logic                      unused_diff_msb;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial           = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        diff            = trial - {1'b0, divisor_q};
        fits            = trial >= {1'b0, divisor_q};
        rem_d           = fits ? diff[DIVISOR_WIDTH-1:0] : trial[DIVISOR_WIDTH-1:0];
        quo_d           = {quo_q[DIVIDEND_WIDTH-2:0], fits};
        unused_diff_msb = diff[DIVISOR_WIDTH];
    end

    // Operand load on start, then DIVIDEND_WIDTH iterations
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (start_i) begin
            rem_q     <= '0;
            quo_q     <= dividend_i;
            divisor_q <= divisor_i;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == CntW'(DIVIDEND_WIDTH - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/auto_contrast_stat.sv
// Per-frame luma min/max statistics and contrast/brightness coefficient generation.
module auto_contrast_stat
    import auto_contrast_stat_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned DIV_ITER    = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3*PIXEL_WIDTH-1:0] di_i,
    input  logic                     de_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    output logic [15:0]              contrast_o,
    output logic [15:0]              brightness_o,
    output logic [PIXEL_WIDTH-1:0]   stat_min_o,
    output logic [PIXEL_WIDTH-1:0]   stat_max_o,
    output logic                     upd_o
);
    localparam int unsigned PW     = PIXEL_WIDTH;
    localparam int unsigned YW     = PW + 3;
    localparam int unsigned MW     = PW + 1;
    localparam int unsigned CntW   = $clog2(DIV_ITER + 1);
    localparam int unsigned CoeRnd = 1 << (COE_FRACTION_WIDTH - 1);
    localparam logic [PW-1:0] PixMax = {PW{1'b1}};

    logic unused_hs;
    assign unused_hs = hs_i;

    // ---------------- luma pipeline ----------------
    logic [PW-1:0] ch_r, ch_g, ch_b;
    logic [YW-1:0] y_sum, y_shr;
    logic [PW-1:0] y_sat;
    logic [PW-1:0] y_q;
    logic          de_q, vs_d1_q, vs_d2_q;
    logic          frame_close;

    assign ch_r = di_i[PW*0 +: PW];
    assign ch_g = di_i[PW*1 +: PW];
    assign ch_b = di_i[PW*2 +: PW];

    // Y = (R + 2G + B + 2) >> 2, saturated
    always_comb begin
        y_sum = YW'(ch_r) + (YW'(ch_g) << 1) + YW'(ch_b) + YW'(2);
        y_shr = y_sum >> 2;
        y_sat = (|y_shr[YW-1:PW]) ? PixMax : y_shr[PW-1:0];
    end

    // Stage 1 register; vs delayed alongside so the close lines up with the accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            de_q    <= 1'b0;
            vs_d1_q <= 1'b0;
            vs_d2_q <= 1'b0;
        end else begin
            y_q     <= y_sat;
            de_q    <= de_i;
            vs_d1_q <= vs_i;
            vs_d2_q <= vs_d1_q;
        end
    end

    assign frame_close = vs_d1_q & ~vs_d2_q;

    // ---------------- accumulators and snapshot ----------------
    logic [PW-1:0] acc_min_q, acc_max_q;
    logic          acc_seen_q;
    logic [PW-1:0] snap_min_q, snap_max_q;
    logic          snap_seen_q;

    // Min/max tracking; the pixel in the close cycle seeds the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_min_q  <= PixMax;
            acc_max_q  <= '0;
            acc_seen_q <= 1'b0;
        end else if (frame_close) begin
            acc_min_q  <= de_q ? y_q : PixMax;
            acc_max_q  <= de_q ? y_q : '0;
            acc_seen_q <= de_q;
        end else if (de_q) begin
            if (y_q < acc_min_q) acc_min_q <= y_q;
            if (y_q > acc_max_q) acc_max_q <= y_q;
            acc_seen_q <= 1'b1;
        end
    end

    // Frame snapshot taken on each close
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_min_q  <= PixMax;
            snap_max_q  <= '0;
            snap_seen_q <= 1'b0;
        end else if (frame_close) begin
            snap_min_q  <= acc_min_q;
            snap_max_q  <= acc_max_q;
            snap_seen_q <= acc_seen_q;
        end
    end

    // ---------------- coefficient arithmetic ----------------
    logic [PW-1:0]           snap_d;
    logic                    snap_deg;
    logic [DIV_ITER-1:0]     div_dividend, div_quo;
    logic                    div_start, div_done, unused_div_busy;
    logic                    deg_q;
    logic [COE_WIDTH-1:0]    coef_q, coef_calc;
    logic [7:0]              bright_q, bright_calc;
    logic [MW-1:0]           mid_sum, mid, delta;
    logic [16:0]             prod, prod_sh;

    // Divider operands, degenerate detection, contrast clamp and brightness product
    always_comb begin
        snap_d       = snap_max_q - snap_min_q;
        snap_deg     = ~snap_seen_q | (snap_max_q == snap_min_q);
        div_dividend = DIV_ITER'(FULL_SCALE_X64) + DIV_ITER'(snap_d >> 1);

        if (deg_q || !div_done) begin
            coef_calc = COE_WIDTH'(COE_ONE);
        end else if (div_quo > DIV_ITER'(COE_MAX)) begin
            coef_calc = COE_WIDTH'(COE_MAX);
        end else begin
            coef_calc = div_quo[COE_WIDTH-1:0];
        end

        mid_sum = MW'(snap_min_q) + MW'(snap_max_q) + MW'(1);
        mid     = mid_sum >> 1;
        delta   = MW'(128) - mid;
        prod    = 17'(coef_q) * 17'(delta) + 17'(CoeRnd);
        prod_sh = prod >> COE_FRACTION_WIDTH;
        if (deg_q || (mid >= MW'(128))) begin
            bright_calc = 8'd0;
        end else if (prod_sh > 17'd255) begin
            bright_calc = 8'hFF;
        end else begin
            bright_calc = prod_sh[7:0];
        end
    end

    auto_contrast_stat_seq_div #(
        .DIVIDEND_WIDTH (DIV_ITER),
        .DIVISOR_WIDTH  (PW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (snap_d),
        .busy_o     (unused_div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // ---------------- FSM ----------------
    acs_state_e      state_q, state_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            out_load;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Next state; a new close always restarts at SNAP, dropping any frame in flight.
    // DIV lasts a fixed time even for degenerate frames to keep latency constant.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_start = 1'b0;
        out_load  = 1'b0;
        if (frame_close) begin
            state_d = StSnap;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StSnap: begin
                    state_d   = StDiv;
                    div_cnt_d = '0;
                    div_start = ~snap_deg;
                end
                StDiv: begin
                    if (div_cnt_q == CntW'(DIV_ITER)) begin
                        state_d = StMul;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                StMul: state_d = StOut;
                StOut: begin
                    state_d  = StIdle;
                    out_load = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Per-state working registers
    always_ff @(posedge clk) begin
        if (rst) begin
            deg_q    <= 1'b1;
            coef_q   <= COE_WIDTH'(COE_ONE);
            bright_q <= 8'd0;
        end else begin
            if (state_q == StSnap) deg_q <= snap_deg;
            if ((state_q == StDiv) && (div_cnt_q == CntW'(DIV_ITER))) coef_q <= coef_calc;
            if (state_q == StMul) bright_q <= bright_calc;
        end
    end

    // Output registers, updated together with the upd_o pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            contrast_o   <= 16'(COE_ONE);
            brightness_o <= 16'd0;
            stat_min_o   <= '0;
            stat_max_o   <= '0;
            upd_o        <= 1'b0;
        end else begin
            upd_o <= out_load;
            if (out_load) begin
                contrast_o   <= 16'(coef_q);
                brightness_o <= 16'(bright_q);
                stat_min_o   <= snap_min_q;
                stat_max_o   <= snap_max_q;
            end
        end
    end

endmodule

// File: tb/tb_auto_contrast_stat.sv
// Self-checking bench for auto_contrast_stat: frames in, scoreboarded coefficient updates out.
module tb_auto_contrast_stat;
    import auto_contrast_stat_pkg::*;

    typedef struct packed {
        logic [15:0] con;
        logic [15:0] bri;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] di_i;
    logic        de_i, hs_i, vs_i;
    logic [15:0] contrast_o, brightness_o;
    logic [7:0]  stat_min_o, stat_max_o;
    logic        upd_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   due_q[$];

    auto_contrast_stat dut (
        .clk          (clk),
        .rst          (rst),
        .di_i         (di_i),
        .de_i         (de_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .contrast_o   (contrast_o),
        .brightness_o (brightness_o),
        .stat_min_o   (stat_min_o),
        .stat_max_o   (stat_max_o),
        .upd_o        (upd_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the coefficient computation
    function automatic res_t model(input logic [23:0] pix[$], input bit de_on);
        int mn, mx, y, d, q, c, b, mid;
        bit seen;
        res_t r;
        mn = 255; mx = 0; seen = 0; c = 64; b = 0;
        if (de_on) begin
            foreach (pix[i]) begin
                y = (int'(pix[i][7:0]) + 2 * int'(pix[i][15:8]) + int'(pix[i][23:16]) + 2) / 4;
                if (y > 255) y = 255;
                if (y < mn) mn = y;
                if (y > mx) mx = y;
                seen = 1;
            end
        end
        if (seen && mx != mn) begin
            d   = mx - mn;
            q   = (16320 + d / 2) / d;
            c   = (q > 511) ? 511 : q;
            mid = (mn + mx + 1) / 2;
            if (mid < 128) begin
                b = (c * (128 - mid) + 32) / 64;
                if (b > 255) b = 255;
            end
        end
        r.con = 16'(c);
        r.bri = 16'(b);
        r.mn  = 8'(mn);
        r.mx  = 8'(mx);
        return r;
    endfunction

    function automatic res_t mk(input int c, input int b, input int mn, input int mx);
        res_t r;
        r.con = 16'(c);
        r.bri = 16'(b);
        r.mn  = 8'(mn);
        r.mx  = 8'(mx);
        return r;
    endfunction

    // Stimulus: one pixel per cycle, then a short blanking gap
    task automatic drive_frame(input logic [23:0] pix[$], input bit de_on);
        foreach (pix[i]) begin
            @(negedge clk);
            di_i = pix[i];
            de_i = de_on;
            hs_i = 1'b0;
        end
        @(negedge clk);
        di_i = '0;
        de_i = 1'b0;
        hs_i = 1'b1;
        repeat (2) @(negedge clk);
        hs_i = 1'b0;
    endtask

    task automatic vs_rise(input res_t e);
        @(negedge clk);
        vs_i = 1'b1;
        exp_q.push_back(e);
        due_q.push_back(cyc + 1 + int'(ACS_LATENCY));
    endtask

    // Bounded wait for upd_o; also drops vs_i a few cycles into the wait
    task automatic wait_upd(input int budget, output bit found, output int at, output res_t obs);
        found = 0;
        at    = 0;
        obs   = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == 2) vs_i = 1'b0;
            if (upd_o === 1'b1) begin
                found = 1;
                at    = cyc;
                obs   = {contrast_o, brightness_o, stat_min_o, stat_max_o};
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (contrast_o !== 16'h0040) begin
            errors++;
            $display("FAIL reset_contrast: got %h, required 0040", contrast_o);
        end
        checks++;
        if (brightness_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_brightness: got %h, required 0000", brightness_o);
        end
        checks++;
        if (stat_min_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_min: got %h, required 00", stat_min_o);
        end
        checks++;
        if (stat_max_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_max: got %h, required 00", stat_max_o);
        end
        checks++;
        if (upd_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_upd: got %b, required 0", upd_o);
        end
    endtask

    task automatic test_ramp();
        logic [23:0] pix[$];
        bit found; int at, due; res_t obs, e;
        for (int v = 16; v <= 235; v++) pix.push_back({8'(v), 8'(v), 8'(v)});
        drive_frame(pix, 1'b1);
        vs_rise(mk(75, 2, 16, 235));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL ramp_latency: upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL ramp_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
        @(negedge clk);
        checks++;
        if (upd_o !== 1'b0) begin
            errors++;
            $display("FAIL ramp_pulse_width: upd_o got %b one cycle later, required 0", upd_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (contrast_o !== e.con || stat_max_o !== e.mx) begin
            errors++;
            $display("FAIL ramp_hold: got con=%0d max=%0d, required %0d %0d",
                     contrast_o, stat_max_o, e.con, e.mx);
        end
    endtask

    task automatic test_flat();
        logic [23:0] pix[$];
        bit found; int at, due; res_t obs, e;
        repeat (40) pix.push_back({8'd100, 8'd100, 8'd100});
        drive_frame(pix, 1'b1);
        vs_rise(mk(64, 0, 100, 100));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL flat_latency: upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL flat_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
    endtask

    task automatic test_no_de();
        logic [23:0] pix[$];
        bit found; int at, due; res_t obs, e;
        for (int v = 0; v < 30; v++) pix.push_back({8'(v * 7), 8'(v * 3), 8'(v * 5)});
        drive_frame(pix, 1'b0);
        vs_rise(mk(64, 0, 255, 0));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL no_de_latency: upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL no_de_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
    endtask

    task automatic test_dark();
        logic [23:0] pix[$];
        bit found; int at, due; res_t obs, e;
        for (int v = 1; v <= 3; v++) pix.push_back({8'(v), 8'(v), 8'(v)});
        drive_frame(pix, 1'b1);
        vs_rise(mk(511, 255, 1, 3));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL dark_latency: upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL dark_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
    endtask

    task automatic test_random();
        logic [23:0] pix[$];
        bit found; int at, due; res_t obs, e;
        for (int f = 0; f < 3; f++) begin
            pix.delete();
            for (int i = 0; i < 24; i++) begin
                pix.push_back({8'($urandom_range(0, 255)), 8'($urandom_range(0, 200)),
                               8'($urandom_range(0, 255))});
            end
            drive_frame(pix, 1'b1);
            vs_rise(model(pix, 1'b1));
            wait_upd(60, found, at, obs);
            e = exp_q.pop_front(); due = due_q.pop_front();
            checks++;
            if (!found || at != due) begin
                errors++;
                $display("FAIL random_latency[%0d]: upd_o at cycle %0d (seen=%0d), required %0d",
                         f, at, found, due);
            end
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random_values[%0d]: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                         f, obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] pix_a[$], pix_b[$];
        bit found; int at, due; res_t obs, e;
        for (int v = 10; v < 40; v++) pix_a.push_back({8'(v), 8'(v), 8'(v)});
        pix_b.push_back({8'd50, 8'd50, 8'd50});
        pix_b.push_back({8'd60, 8'd60, 8'd60});
        pix_b.push_back({8'd200, 8'd200, 8'd200});
        pix_b.push_back({8'd90, 8'd90, 8'd90});
        drive_frame(pix_a, 1'b1);
        // First edge: frame A closes but is overtaken 8 cycles later
        @(negedge clk);
        vs_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vs_i = 1'b0;
        foreach (pix_b[i]) begin
            @(negedge clk);
            di_i = pix_b[i];
            de_i = 1'b1;
        end
        @(negedge clk);
        di_i = '0;
        de_i = 1'b0;
        vs_rise(model(pix_b, 1'b1));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL b2b_latency: first upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL b2b_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
        wait_upd(30, found, at, obs);
        checks++;
        if (found) begin
            errors++;
            $display("FAIL b2b_single_upd: extra upd_o at cycle %0d, required none", at);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] pix[$];
        bit found; int at, due, c0; res_t obs, e;
        for (int v = 30; v < 90; v += 3) pix.push_back({8'(v), 8'(v), 8'(v)});
        drive_frame(pix, 1'b1);
        @(negedge clk);
        vs_i = 1'b1;
        c0 = cyc;
        // Run to the negedge before the 10th DIV cycle, then reset for one edge
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 1) vs_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cyc != c0 + 13) begin
            errors++;
            $display("FAIL rstmid_timing: reset landed at cycle %0d, required %0d", cyc, c0 + 13);
        end
        checks++;
        if ({contrast_o, brightness_o, stat_min_o, stat_max_o} !== {16'h0040, 16'h0000, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_outputs: got con=%h bri=%h min=%h max=%h, required 0040 0000 00 00",
                     contrast_o, brightness_o, stat_min_o, stat_max_o);
        end
        wait_upd(40, found, at, obs);
        checks++;
        if (found) begin
            errors++;
            $display("FAIL rstmid_no_upd: upd_o at cycle %0d after reset, required none", at);
        end
        pix.delete();
        for (int v = 40; v <= 180; v += 20) pix.push_back({8'(v), 8'(v), 8'(v)});
        drive_frame(pix, 1'b1);
        vs_rise(model(pix, 1'b1));
        wait_upd(60, found, at, obs);
        e = exp_q.pop_front(); due = due_q.pop_front();
        checks++;
        if (!found || at != due) begin
            errors++;
            $display("FAIL rstmid_next_latency: upd_o at cycle %0d (seen=%0d), required %0d", at, found, due);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rstmid_next_values: got con=%0d bri=%0d min=%0d max=%0d, required %0d %0d %0d %0d",
                     obs.con, obs.bri, obs.mn, obs.mx, e.con, e.bri, e.mn, e.mx);
        end
    endtask

    initial begin
        rst  = 1'b1;
        di_i = '0;
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_flat();
        test_no_de();
        test_dark();
        test_random();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
